// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, WIDTH data bits MSB-first, optional even parity, stop bit.
// Latency: dout_valid rises on the clk edge that samples the stop bit (frame = 1+WIDTH+PARITY_EN+1 strobes).
// Backpressure: one-word holding buffer; a good frame arriving while it is full and not being read is dropped (sticky overrun).
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   bit_en, sin       sample strobe and serial line (idles high); sin only consumed when bit_en=1
//   dout, dout_valid  received word (first data bit in MSB) and its valid flag
//   dout_ready        consumer accepts dout when dout_valid & dout_ready
//   frame_err         1-cycle pulse when the stop bit is sampled low
//   parity_err        1-cycle pulse when a good-stop frame has odd parity (word still delivered)
//   overrun           sticky flag: a good word was dropped because the buffer was full
module sipo_frame_rx #(
    parameter int WIDTH     = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic             par_bit;

    logic             last_data;
    logic             stop_sample;
    logic             good_frame;
    logic             bad_frame;
    logic             par_mis;
    logic             can_load;

    assign last_data   = (cnt == CW'(WIDTH - 1));
    assign stop_sample = bit_en && (state == STOP);
    assign good_frame  = stop_sample && sin;
    assign bad_frame   = stop_sample && !sin;
    // Even parity over data plus parity bit must XOR to zero.
    assign par_mis     = PARITY_EN && (^{sh, par_bit});
    // Buffer can take a new word if empty or being drained on this same edge.
    assign can_load    = !dout_valid || dout_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the FSM only moves on strobe cycles
    always_comb begin
        state_nxt = state;
        if (bit_en) begin
            case (state)
                IDLE:    if (!sin) state_nxt = DATA;
                DATA:    if (last_data) state_nxt = PARITY_EN ? PARITY : STOP;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Shift register, bit counter and captured parity bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh      <= '0;
            cnt     <= '0;
            par_bit <= 1'b0;
        end else if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!sin) cnt <= '0;
                end
                DATA: begin
                    sh  <= {sh[WIDTH-2:0], sin};
                    cnt <= cnt + CW'(1);
                end
                PARITY: begin
                    par_bit <= sin;
                end
                default: begin
                end
            endcase
        end
    end

    // Holding buffer, handshake and error reporting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= bad_frame;
            parity_err <= good_frame && par_mis;
            if (good_frame && can_load) begin
                dout       <= sh;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (good_frame && !can_load) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Testbench for sipo_frame_rx: directed frames followed by randomized frames, all
// checked every cycle against a frame-level reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_sipo_frame_rx;

    localparam int W    = 4;
    localparam bit PE   = 1'b1;
    localparam int FLEN = 1 + W + (PE ? 1 : 0) + 1;

    logic         clk;
    logic         reset;
    logic         bit_en;
    logic         sin;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic         frame_err;
    logic         parity_err;
    logic         overrun;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic         m_valid;
    logic [W-1:0] m_dout;
    logic         m_ovr;
    logic         m_bits[$];
    logic         e_ferr;
    logic         e_perr;
    logic         perr_known;
    int           rdy_mode;   // 0 = low, 1 = high, 2 = random each cycle

    sipo_frame_rx #(.WIDTH(W), .PARITY_EN(PE)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .sin        (sin),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_dout  = '0;
        m_ovr   = 1'b0;
        m_bits.delete();
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".dout"},       16'(dout),       16'(m_dout));
        chk({tag, ".dout_valid"}, 16'(dout_valid), 16'(m_valid));
        chk({tag, ".frame_err"},  16'(frame_err),  16'(e_ferr));
        if (perr_known) chk({tag, ".parity_err"}, 16'(parity_err), 16'(e_perr));
        chk({tag, ".overrun"},    16'(overrun),    16'(m_ovr));
    endtask

    // One clock cycle: drive inputs, advance, update the model, compare.
    task automatic tick(input logic be, input logic s, input string tag);
        logic         r;
        logic         accept;
        logic         done;
        logic         loaded;
        logic [W-1:0] d;
        logic         pbit;
        logic         stopb;
        r          = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        bit_en     = be;
        sin        = s;
        dout_ready = r;
        @(posedge clk);
        e_ferr     = 1'b0;
        e_perr     = 1'b0;
        perr_known = 1'b1;
        accept     = m_valid && r;
        done       = 1'b0;
        loaded     = 1'b0;
        if (be) begin
            if (m_bits.size() == 0) begin
                if (!s) m_bits.push_back(s);
            end else begin
                m_bits.push_back(s);
                if (m_bits.size() == FLEN) done = 1'b1;
            end
        end
        if (done) begin
            d = '0;
            for (int i = 1; i <= W; i++) d = {d[W-2:0], m_bits[i]};
            pbit  = PE ? m_bits[W+1] : 1'b0;
            stopb = m_bits[FLEN-1];
            m_bits.delete();
            if (!stopb) begin
                e_ferr = 1'b1;
            end else if (!m_valid || r) begin
                m_dout  = d;
                m_valid = 1'b1;
                loaded  = 1'b1;
                e_perr  = PE && (($countones(d) + int'(pbit)) % 2 == 1);
            end else begin
                m_ovr      = 1'b1;
                perr_known = 1'b0;
            end
        end
        if (accept && !loaded) m_valid = 1'b0;
        #1;
        check_outputs(tag);
    endtask

    // Send one frame; gap = idle (non-strobe) cycles before each strobe, with junk on sin.
    task automatic send_frame(input logic [W-1:0] data, input logic pbad,
                              input logic stopb, input int gap, input string tag);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = W - 1; i >= 0; i--) bits.push_back(data[i]);
        if (PE) bits.push_back((^data) ^ pbad);
        bits.push_back(stopb);
        foreach (bits[k]) begin
            for (int g = 0; g < gap; g++) tick(1'b0, 1'($urandom_range(0, 1)), tag);
            tick(1'b1, bits[k], tag);
        end
    endtask

    initial begin
        reset      = 1'b0;
        bit_en     = 1'b0;
        sin        = 1'b1;
        dout_ready = 1'b0;
        rdy_mode   = 1;
        e_ferr     = 1'b0;
        e_perr     = 1'b0;
        perr_known = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        reset = 1'b1;
        tick(1'b1, 1'b1, "idle");

        // 1: good frame 1101 with correct parity, dout_valid on the stop edge
        send_frame(4'b1101, 1'b0, 1'b1, 0, "t1");
        chk("t1.dout_const",  16'(dout),       16'h000d);
        chk("t1.valid_const", 16'(dout_valid), 16'h0001);
        chk("t1.perr_const",  16'(parity_err), 16'h0000);
        tick(1'b1, 1'b1, "t1.after");

        // 2: same frame with parity bit 0; parity_err for exactly one cycle
        send_frame(4'b1101, 1'b1, 1'b1, 0, "t2");
        chk("t2.perr_const", 16'(parity_err), 16'h0001);
        chk("t2.dout_const", 16'(dout),       16'h000d);
        tick(1'b1, 1'b1, "t2.after");
        chk("t2.perr_clear", 16'(parity_err), 16'h0000);

        // 3: stop bit low, then a normal frame
        send_frame(4'b0101, 1'b0, 1'b0, 0, "t3");
        chk("t3.ferr_const",  16'(frame_err),  16'h0001);
        chk("t3.valid_const", 16'(dout_valid), 16'h0000);
        tick(1'b1, 1'b1, "t3.after");
        chk("t3.ferr_clear", 16'(frame_err), 16'h0000);
        send_frame(4'b1001, 1'b0, 1'b1, 0, "t3.next");
        chk("t3.next_dout", 16'(dout), 16'h0009);
        tick(1'b1, 1'b1, "t3.drain");

        // 4: consumer stalled, second word dropped, overrun sticky
        rdy_mode = 0;
        send_frame(4'b1010, 1'b0, 1'b1, 0, "t4a");
        send_frame(4'b0011, 1'b0, 1'b1, 0, "t4b");
        chk("t4.dout_const",  16'(dout),       16'h000a);
        chk("t4.valid_const", 16'(dout_valid), 16'h0001);
        chk("t4.ovr_const",   16'(overrun),    16'h0001);
        rdy_mode = 1;
        tick(1'b1, 1'b1, "t4.drain");
        chk("t4.valid_drop", 16'(dout_valid), 16'h0000);

        // 5: bit_en every third cycle
        send_frame(4'b0110, 1'b0, 1'b1, 2, "t5");
        chk("t5.dout_const", 16'(dout), 16'h0006);
        tick(1'b1, 1'b1, "t5.after");

        // 6: reset after the second data bit, then a clean frame
        tick(1'b1, 1'b0, "t6.start");
        tick(1'b1, 1'b1, "t6.d1");
        tick(1'b1, 1'b0, "t6.d2");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        e_ferr = 1'b0;
        e_perr = 1'b0;
        check_outputs("t6.in_reset");
        chk("t6.ovr_zero", 16'(overrun), 16'h0000);
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_frame(4'b1111, 1'b0, 1'b1, 0, "t6");
        chk("t6.dout_const", 16'(dout), 16'h000f);
        tick(1'b1, 1'b1, "t6.after");

        // Randomized frames, gaps and consumer readiness
        rdy_mode = 2;
        for (int n = 0; n < 300; n++) begin
            int idle_cnt;
            idle_cnt = $urandom_range(0, 3);
            for (int k = 0; k < idle_cnt; k++) tick(1'($urandom_range(0, 1)), 1'b1, "rnd.idle");
            send_frame(W'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) != 0),
                       $urandom_range(0, 2), "rnd");
        end
        rdy_mode = 1;
        repeat (3) tick(1'b1, 1'b1, "rnd.drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
